rvb_clmul_seq: RTL and testbench
================================

RVB_CLMUL_SEQ -- requirements
Module: rvb_clmul_seq

Interface
REQ-001 SHALL have parameter: XLEN, 32, datapath width; legal values 32 and 64 only.
REQ-002 SHALL have port: clock  input  1  single clock; all state changes on posedge.
REQ-003 SHALL have port: resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: din_valid  input  1  request valid from initiator.
REQ-005 SHALL have port: din_ready  output  1  block accepts request this cycle.
REQ-006 SHALL have ports: din_rs1, din_rs2  input  XLEN each  operands; din_rs3  input  XLEN  ignored.
REQ-007 SHALL have port: din_insn  input  32  instruction word.
REQ-008 SHALL have port: dout_valid  output  1  result valid.
REQ-009 SHALL have port: dout_ready  input  1  initiator accepts result.
REQ-010 SHALL have port: dout_rd  output  XLEN  result.

Function
REQ-011 SHALL implement the responder end of the din/dout valid-ready protocol: request transfer when din_valid && din_ready at posedge; result transfer when dout_valid && dout_ready at posedge.
REQ-012 SHALL use FSM states IDLE, BUSY, DONE; din_ready = (state==IDLE); dout_valid = (state==DONE); both outputs registered-state-derived only, no combinational path from din_valid/dout_ready.
REQ-013 SHALL decode, with opcode 0110011 and funct7 0000101: funct3 001 = CLMUL, 011 = CLMULH, 010 = CLMULR; any other din_insn is unsupported.
REQ-014 On request transfer SHALL latch rs1, rs2, op, clear 2*XLEN accumulator P, clear step counter, go BUSY (supported) or DONE with dout_rd = 0 (unsupported).
REQ-015 In BUSY each cycle SHALL process the next R bits of rs2, LSB first: for each bit i set, P ^= rs1 << i; R = 1 by default (see Configuration).
REQ-016 After XLEN/R BUSY cycles SHALL go DONE with dout_rd = P[XLEN-1:0] (CLMUL), P[2*XLEN-1:XLEN] (CLMULH), P[2*XLEN-2:XLEN-1] (CLMULR).
REQ-017 Latency: request accepted at edge E -> dout_valid high after edge E+XLEN/R (supported), after edge E (unsupported).
REQ-018 In DONE, dout_rd SHALL be held stable until result transfer; dout_ready low for any number of cycles SHALL not alter dout_rd or state.
REQ-019 On result transfer SHALL return to IDLE; din_ready rises the cycle after, never in the same cycle as dout_valid (one request in flight).
REQ-020 din_valid and operand changes while not IDLE SHALL be ignored; dout_ready while not DONE SHALL be ignored.
REQ-021 Step counter SHALL be log2(XLEN)+1 bits wide and never wrap during an operation.

Reset
REQ-022 resetn low SHALL asynchronously force state IDLE, counter 0, P 0, dout_rd 0; din_ready = 1 and dout_valid = 0 while and after reset.
REQ-023 resetn asserted mid-BUSY or mid-DONE SHALL abort the operation; pending result is discarded and never presented.
REQ-024 First request SHALL be accepted no earlier than the first posedge after resetn deasserts.

Configuration
REQ-025 Macro RVB_CLMUL_RADIX4_EN defined: R = 4 (four rs2 bits per BUSY cycle, XLEN/4 cycles); undefined: R = 1 (XLEN cycles); results bit-identical in both builds.

Verification
REQ-026 XLEN=32, CLMUL (insn 0x0A0090B3), rs1=0x3, rs2=0x3 -> dout_rd=0x00000005, dout_valid after edge E+32 (E+8 with RADIX4).
REQ-027 XLEN=32, CLMULH (insn 0x0A00B0B3), rs1=rs2=0x80000000 -> dout_rd=0x40000000; CLMULR (insn 0x0A00A0B3), same operands -> 0x80000000.
REQ-028 XLEN=64, CLMUL rs1=0xFFFFFFFFFFFFFFFF, rs2=0x3 -> dout_rd=0x0000000000000001; CLMULH same -> 0x0000000000000001.
REQ-029 Unsupported insn 0x00000033 (ADD), rs1=5, rs2=7 -> dout_rd=0, dout_valid after edge E; din_ready low until result transfer.
REQ-030 Backpressure: dout_ready held low 10 cycles in DONE -> dout_rd stable, din_ready 0, din_valid pulses ignored; one dout_ready pulse -> IDLE next cycle.
REQ-031 resetn pulsed low 3 cycles into BUSY -> dout_valid never asserts for aborted request; next request completes with correct result.

Source files
------------

// File: rtl/rvb_clmul_seq_if.sv
// rvb_clmul_seq_if: request/result valid-ready bundle for rvb_clmul_seq.
// master = initiator side, slave = the multiplier.
interface rvb_clmul_seq_if #(parameter int XLEN = 32);
    logic            din_valid;
    logic            din_ready;
    logic [XLEN-1:0] din_rs1;
    logic [XLEN-1:0] din_rs2;
    logic [XLEN-1:0] din_rs3;
    logic [31:0]     din_insn;
    logic            dout_valid;
    logic            dout_ready;
    logic [XLEN-1:0] dout_rd;
    modport master (
        output din_valid, din_rs1, din_rs2, din_rs3, din_insn, dout_ready,
        input  din_ready, dout_valid, dout_rd
    );
    modport slave (
        input  din_valid, din_rs1, din_rs2, din_rs3, din_insn, dout_ready,
        output din_ready, dout_valid, dout_rd
    );
endinterface

// File: rtl/rvb_clmul_seq.sv
// rvb_clmul_seq: sequential carry-less multiply (CLMUL/CLMULH/CLMULR), one request in flight.
// Define RVB_CLMUL_RADIX4_EN to retire four rs2 bits per BUSY cycle instead of one.
module rvb_clmul_seq #(
    parameter int XLEN = 32
) (
    input logic            clock,
    input logic            resetn,
    rvb_clmul_seq_if.slave io
);
`ifdef RVB_CLMUL_RADIX4_EN
    localparam int R = 4;
`else
    localparam int R = 1;
`endif
    localparam int STEPS = XLEN / R;
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {OP_CLMUL, OP_CLMULH, OP_CLMULR} op_t;

    state_t            state;
    op_t               op;
    op_t               dec_op;
    logic              dec_ok;
    logic [2*XLEN-1:0] a;
    logic [2*XLEN-1:0] p;
    logic [2*XLEN-1:0] p_next;
    logic [XLEN-1:0]   b;
    logic [XLEN-1:0]   rd;
    logic [XLEN-1:0]   res;
    logic [CW-1:0]     cnt;
    logic [2:0]        f3;
    logic              unused_ok;

    assign f3 = io.din_insn[14:12];
    assign dec_ok = io.din_insn[6:0] == 7'b0110011 && io.din_insn[31:25] == 7'b0000101 &&
                    (f3 == 3'b001 || f3 == 3'b011 || f3 == 3'b010);
    assign dec_op = f3 == 3'b011 ? OP_CLMULH : f3 == 3'b010 ? OP_CLMULR : OP_CLMUL;
    assign unused_ok = ^{io.din_rs3, io.din_insn[24:15], io.din_insn[11:7]};

    // a is rs1 pre-shifted to the current bit position; b is rs2 with consumed bits shifted out
    always_comb begin
        p_next = p;
        for (int i = 0; i < R; i++)
            if (b[i]) p_next = p_next ^ (a << i);
    end

    assign res = op == OP_CLMULH ? p_next[2*XLEN-1:XLEN] :
                 op == OP_CLMULR ? p_next[2*XLEN-2:XLEN-1] : p_next[XLEN-1:0];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            op    <= OP_CLMUL;
            a     <= '0;
            b     <= '0;
            p     <= '0;
            cnt   <= '0;
            rd    <= '0;
        end else begin
            case (state)
                IDLE: if (io.din_valid) begin
                    a     <= {{XLEN{1'b0}}, io.din_rs1};
                    b     <= io.din_rs2;
                    op    <= dec_op;
                    p     <= '0;
                    cnt   <= '0;
                    rd    <= '0;
                    state <= dec_ok ? BUSY : DONE;
                end
                BUSY: begin
                    p   <= p_next;
                    a   <= a << R;
                    b   <= b >> R;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(STEPS - 1)) begin
                        rd    <= res;
                        state <= DONE;
                    end
                end
                DONE: if (io.dout_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign io.din_ready  = state == IDLE;
    assign io.dout_valid = state == DONE;
    assign io.dout_rd    = rd;
endmodule

// File: tb/tb_rvb_clmul_seq.sv
// tb_rvb_clmul_seq: random + directed check of rvb_clmul_seq at XLEN 32 and 64 against
// a product-level carry-less multiply model; outputs compared every cycle on the falling edge.
module tb_rvb_clmul_seq;
`ifdef RVB_CLMUL_RADIX4_EN
    localparam int R = 4;
`else
    localparam int R = 1;
`endif
    localparam logic [31:0] I_CLMUL  = 32'h0A0090B3;
    localparam logic [31:0] I_CLMULH = 32'h0A00B0B3;
    localparam logic [31:0] I_CLMULR = 32'h0A00A0B3;
    localparam logic [31:0] I_ADD    = 32'h00000033;

    logic clock;
    logic resetn;
    int   asserts = 0;
    int   fails = 0;

    rvb_clmul_seq_if #(.XLEN(32)) i32 ();
    rvb_clmul_seq_if #(.XLEN(64)) i64 ();

    rvb_clmul_seq #(.XLEN(32)) u32 (.clock(clock), .resetn(resetn), .io(i32.slave));
    rvb_clmul_seq #(.XLEN(64)) u64 (.clock(clock), .resetn(resetn), .io(i64.slave));

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    // what the bench last drove, per instance (0 = XLEN 32, 1 = XLEN 64)
    logic        s_dv [2];
    logic        s_dr [2];
    logic [31:0] s_insn [2];
    logic [63:0] s_a [2];
    logic [63:0] s_b [2];

    // model: 0 idle, 1 computing, 2 result pending
    int          m_st [2];
    int          m_left [2];
    logic        m_fresh [2];
    logic [63:0] m_rd [2];

    function automatic logic sup(input logic [31:0] insn);
        return insn[6:0] == 7'h33 && insn[31:25] == 7'h05 &&
               (insn[14:12] == 3'd1 || insn[14:12] == 3'd2 || insn[14:12] == 3'd3);
    endfunction

    function automatic logic [63:0] ref_op(input logic [31:0] insn, input logic [63:0] a_in,
                                           input logic [63:0] b_in, input int xl);
        logic [127:0] prod;
        logic [127:0] m;
        logic [63:0]  a;
        logic [63:0]  b;
        m = (xl == 64) ? {64'b0, {64{1'b1}}} : {96'b0, 32'hFFFF_FFFF};
        a = a_in & m[63:0];
        b = b_in & m[63:0];
        prod = '0;
        for (int i = 0; i < xl; i++)
            if (b[i]) prod = prod ^ ({64'b0, a} << i);
        if (!sup(insn)) return 64'd0;
        if (insn[14:12] == 3'd1) prod = prod & m;
        else if (insn[14:12] == 3'd3) prod = (prod >> xl) & m;
        else prod = (prod >> (xl - 1)) & m;
        return prod[63:0];
    endfunction

    function automatic logic [63:0] got_rd(input int w);
        return w == 1 ? i64.dout_rd : {32'b0, i32.dout_rd};
    endfunction

    task automatic chk(input string nm, input int w, input logic [63:0] got, input logic [63:0] want);
        asserts++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s xlen=%0d t=%0t got=%h expected=%h", nm, w == 1 ? 64 : 32, $time, got, want);
        end
    endtask

    task automatic setin(input int w, input logic dv, input logic [31:0] insn,
                         input logic [63:0] a, input logic [63:0] b, input logic dr);
        s_dv[w] = dv; s_insn[w] = insn; s_a[w] = a; s_b[w] = b; s_dr[w] = dr;
        if (w == 1) begin
            i64.din_valid = dv; i64.din_insn = insn; i64.din_rs1 = a; i64.din_rs2 = b;
            i64.din_rs3 = {$urandom, $urandom}; i64.dout_ready = dr;
        end else begin
            i32.din_valid = dv; i32.din_insn = insn; i32.din_rs1 = a[31:0]; i32.din_rs2 = b[31:0];
            i32.din_rs3 = $urandom; i32.dout_ready = dr;
        end
    endtask

    task automatic step(input int w);
        if (!resetn) begin
            m_st[w] = 0;
            m_fresh[w] = 1;
        end else if (m_st[w] == 0) begin
            if (s_dv[w]) begin
                m_rd[w] = ref_op(s_insn[w], s_a[w], s_b[w], w == 1 ? 64 : 32);
                m_fresh[w] = 0;
                m_left[w] = (w == 1 ? 64 : 32) / R;
                m_st[w] = sup(s_insn[w]) ? 1 : 2;
            end
        end else if (m_st[w] == 1) begin
            m_left[w]--;
            if (m_left[w] == 0) m_st[w] = 2;
        end else if (s_dr[w]) begin
            m_st[w] = 0;
        end
    endtask

    task automatic compare(input int w);
        chk("din_ready", w, {63'b0, w == 1 ? i64.din_ready : i32.din_ready}, {63'b0, m_st[w] == 0});
        chk("dout_valid", w, {63'b0, w == 1 ? i64.dout_valid : i32.dout_valid}, {63'b0, m_st[w] == 2});
        if (m_st[w] == 2 || m_fresh[w]) chk("dout_rd", w, got_rd(w), m_st[w] == 2 ? m_rd[w] : 64'd0);
    endtask

    task automatic tick();
        @(posedge clock);
        for (int w = 0; w < 2; w++) step(w);
        @(negedge clock);
        for (int w = 0; w < 2; w++) compare(w);
    endtask

    task automatic run(input int w, input logic [31:0] insn, input logic [63:0] a,
                       input logic [63:0] b, input int hold);
        int n;
        setin(w, 1, insn, a, b, 0);
        tick();
        n = 0;
        while (m_st[w] != 2 && n < 200) begin
            setin(w, 1'($urandom), $urandom, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
            tick();
            n++;
        end
        if (m_st[w] != 2) chk("completion_timeout", w, 64'(n), 64'd200 - 64'd1);
        for (int i = 0; i < hold; i++) begin
            setin(w, 1'($urandom), $urandom, {$urandom, $urandom}, {$urandom, $urandom}, 0);
            tick();
        end
        setin(w, 0, 0, 0, 0, 1);
        tick();
        setin(w, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [31:0] rand_insn();
        logic [31:0] ins;
        int k;
        ins = $urandom;
        k = $urandom_range(0, 3);
        if (k < 3) begin
            ins[6:0] = 7'h33;
            ins[31:25] = 7'h05;
            ins[14:12] = k == 0 ? 3'd1 : k == 1 ? 3'd3 : 3'd2;
        end
        return ins;
    endfunction

    initial begin
        for (int w = 0; w < 2; w++) begin
            setin(w, 0, 0, 0, 0, 0);
            m_st[w] = 0; m_left[w] = 0; m_fresh[w] = 1; m_rd[w] = 0;
        end
        resetn = 1;
        #2 resetn = 0;
        chk("pin_clmul", 0, ref_op(I_CLMUL, 3, 3, 32), 64'h5);
        chk("pin_clmulh", 0, ref_op(I_CLMULH, 64'h80000000, 64'h80000000, 32), 64'h40000000);
        chk("pin_clmulr", 0, ref_op(I_CLMULR, 64'h80000000, 64'h80000000, 32), 64'h80000000);
        chk("pin_clmul64", 1, ref_op(I_CLMUL, '1, 3, 64), 64'h1);
        chk("pin_clmulh64", 1, ref_op(I_CLMULH, '1, 3, 64), 64'h1);
        chk("pin_add", 0, ref_op(I_ADD, 5, 7, 32), 64'h0);
        repeat (3) tick();
        resetn = 1;
        tick();

        run(0, I_CLMUL, 3, 3, 0);
        run(0, I_CLMULH, 64'h80000000, 64'h80000000, 1);
        run(0, I_CLMULR, 64'h80000000, 64'h80000000, 0);
        run(0, I_ADD, 5, 7, 2);
        run(0, I_CLMUL, 64'hDEADBEEF, 64'h12345678, 10);
        run(1, I_CLMUL, '1, 3, 0);
        run(1, I_CLMULH, '1, 3, 0);
        run(1, I_CLMULR, '1, '1, 3);
        run(1, I_ADD, 5, 7, 0);

        // abort a 32-bit operation three cycles into its computation
        setin(0, 1, I_CLMUL, {$urandom, $urandom}, {$urandom, $urandom}, 0);
        tick();
        setin(0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        resetn = 0;
        repeat (2) tick();
        resetn = 1;
        repeat (40) tick();
        run(0, I_CLMUL, 64'h0000F00F, 64'h00000101, 0);

        for (int i = 0; i < 40; i++)
            run(0, rand_insn(), {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3));
        for (int i = 0; i < 30; i++)
            run(1, rand_insn(), {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3));

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
